lock_ctrl: RTL and testbench

Sequencing controller for the DE1-SoC combination lock. It accepts one BCD digit per `enter` strobe and compares each entry against a stored 6-digit code. It also tracks failed attempts, lets the code be reprogrammed while open, and selects which message the HEX display path renders. The block sits between the debounced switch/key front end and the seven-segment decoders in the lock top level.

---
 rtl/lock_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lock_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl.sv
// Combination-lock sequencer: BCD digit entry, failed-attempt tracking, code reprogramming, HEX message select.
// Define LOCK_LOCKOUT_EN to build the timed LOCKOUT state entered after MAX_FAIL consecutive failures.
module lock_ctrl #(
   parameter int DIGITS      = 6,
   parameter int MAX_FAIL    = 3,
   parameter int LOCKOUT_CYC = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit,
   input  logic       enter,
   input  logic       relock,
   input  logic       prog,
   output logic [1:0] disp_mode,
   output logic [3:0] disp_digit,
   output logic       unlocked,
   output logic [1:0] fail_cnt,
   output logic       locked_out,
   output logic [2:0] pos
);

   localparam logic [2:0] S_CLOSED  = 3'd0;
   localparam logic [2:0] S_ENTRY   = 3'd1;
   localparam logic [2:0] S_OPEN    = 3'd2;
   localparam logic [2:0] S_PROG    = 3'd3;
   localparam logic [2:0] S_ERROR   = 3'd4;
`ifdef LOCK_LOCKOUT_EN
   localparam logic [2:0] S_LOCKOUT = 3'd5;
`endif

   localparam logic [2:0]  LAST_POS   = 3'(DIGITS - 1);
   localparam logic [1:0]  FAIL_MAX   = 2'(MAX_FAIL);
   // Factory combination 3,0,5,4,6,4 with position 0 in the low nibble.
   localparam logic [23:0] RESET_CODE = 24'h464503;

   // An out-of-range parameter set elaborates this marker block.
   if (DIGITS < 2 || DIGITS > 8 || MAX_FAIL < 1 || MAX_FAIL > 3 || LOCKOUT_CYC < 1) begin : g_illegal_params
   end

   logic [2:0] state;
   logic       mismatch;
   logic       prog_seen;
   logic [3:0] code   [DIGITS];
   logic [3:0] shadow [DIGITS];

   logic       digit_bad;
   logic       attempt_miss;
   logic [1:0] fail_bumped;

   // NOTE: always_comb uses blocking assignments and sets every output on every path, so no latch is inferred.
   always_comb begin
      digit_bad    = digit > 4'd9;
      attempt_miss = mismatch | digit_bad | (digit != code[pos]);
      fail_bumped  = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 2'd1;
   end

`ifdef LOCK_LOCKOUT_EN
   localparam int CNT_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   logic [CNT_W-1:0] lock_cnt;

   // Preloaded while outside LOCKOUT so the state lasts exactly LOCKOUT_CYC cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lock_cnt <= '0;
      else if (state != S_LOCKOUT)
         lock_cnt <= CNT_W'(LOCKOUT_CYC - 1);
      else if (lock_cnt != '0)
         lock_cnt <= lock_cnt - 1'b1;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_CLOSED;
         pos        <= '0;
         mismatch   <= 1'b0;
         prog_seen  <= 1'b0;
         fail_cnt   <= '0;
         disp_digit <= '0;
         // NOTE: the code array is reset deliberately (factory combination); the shadow array is not.
         for (int i = 0; i < DIGITS; i++)
            code[i] <= RESET_CODE[4*(i % 6) +: 4];
      end else begin
         case (state)
            S_CLOSED, S_ENTRY: if (enter) begin
               disp_digit <= digit;
               if (pos == LAST_POS) begin
                  pos      <= '0;
                  mismatch <= 1'b0;
                  if (!attempt_miss) begin
                     state    <= S_OPEN;
                     fail_cnt <= '0;
                  end else begin
                     fail_cnt <= fail_bumped;
`ifdef LOCK_LOCKOUT_EN
                     state    <= (fail_bumped == FAIL_MAX) ? S_LOCKOUT : S_ERROR;
`else
                     state    <= S_ERROR;
`endif
                  end
               end else begin
                  pos      <= pos + 3'd1;
                  mismatch <= attempt_miss;
                  state    <= S_ENTRY;
               end
            end
            S_ERROR: if (enter) state <= S_CLOSED;
            S_OPEN: begin
               if (relock)
                  state <= S_CLOSED;
               else if (prog) begin
                  state     <= S_PROG;
                  pos       <= '0;
                  prog_seen <= 1'b0;
               end
            end
            S_PROG: begin
               if (relock) begin
                  state <= S_CLOSED;
                  pos   <= '0;
               end else if (enter && !digit_bad) begin
                  disp_digit <= digit;
                  prog_seen  <= 1'b1;
                  if (pos == LAST_POS) begin
                     for (int i = 0; i < DIGITS - 1; i++)
                        code[i] <= shadow[i];
                     code[DIGITS-1] <= digit;
                     pos            <= '0;
                     state          <= S_OPEN;
                  end else begin
                     pos <= pos + 3'd1;
                  end
               end
            end
`ifdef LOCK_LOCKOUT_EN
            S_LOCKOUT: if (lock_cnt == '0) begin
               state    <= S_CLOSED;
               fail_cnt <= '0;
            end
`endif
            default: state <= S_CLOSED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_PROG && !relock && enter && !digit_bad)
         shadow[pos] <= digit;
   end

   always_comb begin
      case (state)
         S_CLOSED: disp_mode = 2'b10;
         S_ENTRY:  disp_mode = 2'b00;
         S_OPEN:   disp_mode = 2'b01;
         S_PROG:   disp_mode = prog_seen ? 2'b00 : 2'b01;
         default:  disp_mode = 2'b11;
      endcase
   end

   assign unlocked = (state == S_OPEN) || (state == S_PROG);
`ifdef LOCK_LOCKOUT_EN
   assign locked_out = (state == S_LOCKOUT);
`else
   assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl: directed scenarios plus randomized traffic against a queue-based model.
// Build with LOCK_LOCKOUT_EN defined or not; the model follows the same macro.
module tb_lock_ctrl;

   localparam int DIGITS      = 6;
   localparam int MAX_FAIL    = 3;
   localparam int LOCKOUT_CYC = 16;
`ifdef LOCK_LOCKOUT_EN
   localparam bit LOCKOUT_EN = 1'b1;
`else
   localparam bit LOCKOUT_EN = 1'b0;
`endif

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic [3:0] digit  = 4'd0;
   logic       enter  = 1'b0;
   logic       relock = 1'b0;
   logic       prog   = 1'b0;
   logic [1:0] disp_mode;
   logic [3:0] disp_digit;
   logic       unlocked;
   logic [1:0] fail_cnt;
   logic       locked_out;
   logic [2:0] pos;
   logic [12:0] dut_out;

   int vectors     = 0;
   int miscompares = 0;

   int DEF_CODE[6] = '{3, 0, 5, 4, 6, 4};
   int WRONG[6]    = '{3, 0, 5, 4, 6, 5};
   int BAD[6]      = '{3, 10, 5, 4, 6, 4};
   int NEW_CODE[6] = '{1, 2, 3, 4, 5, 6};

   lock_ctrl #(.DIGITS(DIGITS), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC)) dut (
      .clk        (clk),
      .reset      (reset),
      .digit      (digit),
      .enter      (enter),
      .relock     (relock),
      .prog       (prog),
      .disp_mode  (disp_mode),
      .disp_digit (disp_digit),
      .unlocked   (unlocked),
      .fail_cnt   (fail_cnt),
      .locked_out (locked_out),
      .pos        (pos)
   );

   assign dut_out = {disp_mode, disp_digit, unlocked, fail_cnt, locked_out, pos};

   always #5 clk = ~clk;

   // Reference model: the attempt and the reprogramming buffer are digit queues judged when full.
   int m_code[6];
   int m_att[$];
   int m_plist[$];
   bit m_open, m_prog, m_err;
   int m_lock, m_fail, m_last;

   function automatic void model_reset();
      foreach (DEF_CODE[i]) m_code[i] = DEF_CODE[i];
      m_att.delete();
      m_plist.delete();
      m_open = 1'b0; m_prog = 1'b0; m_err = 1'b0;
      m_lock = 0; m_fail = 0; m_last = 0;
   endfunction

   function automatic void model_step(input bit e, input int d, input bit r, input bit p);
      bit ok;
      if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_fail = 0;
      end else if (m_err) begin
         if (e) m_err = 1'b0;
      end else if (m_prog) begin
         if (r) begin
            m_prog = 1'b0; m_open = 1'b0; m_plist.delete();
         end else if (e && d <= 9) begin
            m_plist.push_back(d);
            m_last = d;
            if (m_plist.size() == DIGITS) begin
               foreach (m_code[i]) m_code[i] = m_plist[i];
               m_plist.delete();
               m_prog = 1'b0;
            end
         end
      end else if (m_open) begin
         if (r) m_open = 1'b0;
         else if (p) m_prog = 1'b1;
      end else if (e) begin
         m_att.push_back(d);
         m_last = d;
         if (m_att.size() == DIGITS) begin
            ok = 1'b1;
            foreach (m_att[i]) if (m_att[i] != m_code[i]) ok = 1'b0;
            m_att.delete();
            if (ok) begin
               m_open = 1'b1; m_fail = 0;
            end else begin
               if (m_fail < MAX_FAIL) m_fail++;
               if (LOCKOUT_EN && m_fail == MAX_FAIL) m_lock = LOCKOUT_CYC;
               else m_err = 1'b1;
            end
         end
      end
   endfunction

   function automatic logic [12:0] exp_out();
      int mode, p;
      p = m_prog ? m_plist.size() : m_att.size();
      if (m_lock > 0 || m_err)  mode = 3;
      else if (m_prog)          mode = (m_plist.size() == 0) ? 1 : 0;
      else if (m_open)          mode = 1;
      else if (m_att.size() > 0) mode = 0;
      else                      mode = 2;
      return {2'(mode), 4'(m_last), m_open, 2'(m_fail), (m_lock > 0), 3'(p)};
   endfunction

   task automatic apply(input bit e, input logic [3:0] d, input bit r, input bit p);
      enter = e; digit = d; relock = r; prog = p;
      @(posedge clk);
      model_step(e, int'(d), r, p);
      #1;
      enter = 1'b0; relock = 1'b0; prog = 1'b0;
   endtask

   task automatic enter_code(input int c[6], input string tag);
      for (int i = 0; i < DIGITS; i++) begin
         apply(1'b1, 4'(c[i]), 1'b0, 1'b0);
         if (dut_out !== exp_out()) begin
            $display("FAIL %s[%0d]: dut=%h model=%h", tag, i, dut_out, exp_out());
            miscompares++;
         end
         vectors++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      if (dut_out !== {2'b10, 4'd0, 1'b0, 2'd0, 1'b0, 3'd0}) begin
         $display("FAIL reset_values: dut=%h want=%h", dut_out, {2'b10, 4'd0, 1'b0, 2'd0, 1'b0, 3'd0});
         miscompares++;
      end
      vectors++;
      @(negedge clk);
      reset = 1'b0;
      apply(1'b0, 4'd0, 1'b0, 1'b0);
      if (dut_out !== exp_out()) begin
         $display("FAIL reset_idle: dut=%h model=%h", dut_out, exp_out());
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_open();
      for (int i = 0; i < DIGITS; i++) begin
         apply(1'b1, 4'(DEF_CODE[i]), 1'b0, 1'b0);
         if (dut_out !== exp_out()) begin
            $display("FAIL open_seq[%0d]: dut=%h model=%h", i, dut_out, exp_out());
            miscompares++;
         end
         vectors++;
         if (i < DIGITS - 1) begin
            if (disp_mode !== 2'b00 || disp_digit !== 4'(DEF_CODE[i]) || pos !== 3'(i + 1)) begin
               $display("FAIL open_track[%0d]: mode=%b digit=%0d pos=%0d want 00/%0d/%0d",
                        i, disp_mode, disp_digit, pos, DEF_CODE[i], i + 1);
               miscompares++;
            end
            vectors++;
         end
      end
      if (disp_mode !== 2'b01 || unlocked !== 1'b1 || fail_cnt !== 2'd0) begin
         $display("FAIL open_done: mode=%b unlocked=%b fail=%0d want 01/1/0", disp_mode, unlocked, fail_cnt);
         miscompares++;
      end
      vectors++;
      apply(1'b0, 4'd0, 1'b1, 1'b0);
      if (disp_mode !== 2'b10 || unlocked !== 1'b0 || dut_out !== exp_out()) begin
         $display("FAIL open_relock: dut=%h model=%h", dut_out, exp_out());
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_wrong_code();
      for (int i = 0; i < DIGITS; i++) begin
         apply(1'b1, 4'(WRONG[i]), 1'b0, 1'b0);
         if (dut_out !== exp_out() || (i < DIGITS - 1 && disp_mode !== 2'b00)) begin
            $display("FAIL wrong_seq[%0d]: dut=%h model=%h", i, dut_out, exp_out());
            miscompares++;
         end
         vectors++;
      end
      if (disp_mode !== 2'b11 || fail_cnt !== 2'd1) begin
         $display("FAIL wrong_error: mode=%b fail=%0d want 11/1", disp_mode, fail_cnt);
         miscompares++;
      end
      vectors++;
      apply(1'b1, 4'd7, 1'b0, 1'b0);
      if (disp_mode !== 2'b10 || pos !== 3'd0 || dut_out !== exp_out()) begin
         $display("FAIL wrong_clear: mode=%b pos=%0d want 10/0", disp_mode, pos);
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_bad_digit();
      for (int i = 0; i < DIGITS; i++) begin
         apply(1'b1, 4'(BAD[i]), 1'b0, 1'b0);
         if (i < DIGITS - 1 && (pos !== 3'(i + 1) || disp_mode !== 2'b00)) begin
            $display("FAIL bad_step[%0d]: pos=%0d mode=%b want %0d/00", i, pos, disp_mode, i + 1);
            miscompares++;
         end
         if (dut_out !== exp_out()) begin
            $display("FAIL bad_seq[%0d]: dut=%h model=%h", i, dut_out, exp_out());
            miscompares++;
         end
         vectors++;
      end
      if (disp_mode !== 2'b11 || unlocked !== 1'b0) begin
         $display("FAIL bad_error: mode=%b unlocked=%b want 11/0", disp_mode, unlocked);
         miscompares++;
      end
      vectors++;
      apply(1'b1, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic test_fail_limit();
      // Two failures are already on record here; this one reaches MAX_FAIL.
      enter_code(WRONG, "limit_a");
      if (LOCKOUT_EN) begin
         if (locked_out !== 1'b1 || disp_mode !== 2'b11) begin
            $display("FAIL lockout_enter: locked_out=%b mode=%b want 1/11", locked_out, disp_mode);
            miscompares++;
         end
         vectors++;
         for (int k = 1; k <= LOCKOUT_CYC; k++) begin
            apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            if (locked_out !== (k < LOCKOUT_CYC) || dut_out !== exp_out()) begin
               $display("FAIL lockout_hold[%0d]: dut=%h model=%h", k, dut_out, exp_out());
               miscompares++;
            end
            vectors++;
         end
         if (disp_mode !== 2'b10 || fail_cnt !== 2'd0) begin
            $display("FAIL lockout_exit: mode=%b fail=%0d want 10/0", disp_mode, fail_cnt);
            miscompares++;
         end
         vectors++;
      end else begin
         if (disp_mode !== 2'b11 || fail_cnt !== 2'd3 || locked_out !== 1'b0) begin
            $display("FAIL limit_error: mode=%b fail=%0d lo=%b want 11/3/0", disp_mode, fail_cnt, locked_out);
            miscompares++;
         end
         vectors++;
         apply(1'b1, 4'd0, 1'b0, 1'b0);
         enter_code(WRONG, "limit_b");
         if (fail_cnt !== 2'd3) begin
            $display("FAIL limit_saturate: fail=%0d want 3", fail_cnt);
            miscompares++;
         end
         vectors++;
         apply(1'b1, 4'd0, 1'b0, 1'b0);
         enter_code(DEF_CODE, "limit_open");
         if (fail_cnt !== 2'd0 || unlocked !== 1'b1) begin
            $display("FAIL limit_clear: fail=%0d unlocked=%b want 0/1", fail_cnt, unlocked);
            miscompares++;
         end
         vectors++;
         apply(1'b0, 4'd0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_prog();
      enter_code(DEF_CODE, "prog_open");
      apply(1'b0, 4'd0, 1'b0, 1'b1);
      if (disp_mode !== 2'b01 || unlocked !== 1'b1 || pos !== 3'd0) begin
         $display("FAIL prog_enter: mode=%b unlocked=%b pos=%0d want 01/1/0", disp_mode, unlocked, pos);
         miscompares++;
      end
      vectors++;
      for (int i = 0; i < DIGITS; i++) begin
         if (i == 2) begin
            apply(1'b1, 4'hC, 1'b0, 1'b0);
            if (pos !== 3'd2 || dut_out !== exp_out()) begin
               $display("FAIL prog_invalid: pos=%0d want 2", pos);
               miscompares++;
            end
            vectors++;
         end
         apply(1'b1, 4'(NEW_CODE[i]), 1'b0, 1'b0);
         if (dut_out !== exp_out() || (i == 0 && disp_mode !== 2'b00)) begin
            $display("FAIL prog_seq[%0d]: dut=%h model=%h", i, dut_out, exp_out());
            miscompares++;
         end
         vectors++;
      end
      if (disp_mode !== 2'b01 || unlocked !== 1'b1) begin
         $display("FAIL prog_done: mode=%b unlocked=%b want 01/1", disp_mode, unlocked);
         miscompares++;
      end
      vectors++;
      apply(1'b0, 4'd0, 1'b1, 1'b0);
      enter_code(DEF_CODE, "prog_oldcode");
      if (disp_mode !== 2'b11) begin
         $display("FAIL prog_oldcode_rejected: mode=%b want 11", disp_mode);
         miscompares++;
      end
      vectors++;
      apply(1'b1, 4'd0, 1'b0, 1'b0);
      enter_code(NEW_CODE, "prog_newcode");
      if (unlocked !== 1'b1) begin
         $display("FAIL prog_newcode_opens: unlocked=%b want 1", unlocked);
         miscompares++;
      end
      vectors++;
      apply(1'b0, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) apply(1'b1, 4'(7 + i), 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b1, 1'b0);
      if (disp_mode !== 2'b10 || dut_out !== exp_out()) begin
         $display("FAIL prog_abort: dut=%h model=%h", dut_out, exp_out());
         miscompares++;
      end
      vectors++;
      enter_code(NEW_CODE, "prog_after_abort");
      if (unlocked !== 1'b1) begin
         $display("FAIL prog_abort_keeps_code: unlocked=%b want 1", unlocked);
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_async_reset();
      // Lock is open on the reprogrammed code; start a partial PROG then reset between edges.
      apply(1'b0, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) apply(1'b1, 4'(i + 1), 1'b0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      if (dut_out !== {2'b10, 4'd0, 1'b0, 2'd0, 1'b0, 3'd0}) begin
         $display("FAIL async_reset: dut=%h want=%h", dut_out, {2'b10, 4'd0, 1'b0, 2'd0, 1'b0, 3'd0});
         miscompares++;
      end
      vectors++;
      @(negedge clk);
      reset = 1'b0;
      enter_code(DEF_CODE, "reset_code_back");
      if (unlocked !== 1'b1) begin
         $display("FAIL reset_code_reverts: unlocked=%b want 1", unlocked);
         miscompares++;
      end
      vectors++;
      apply(1'b1, 4'd3, 1'b1, 1'b0);
      if (disp_mode !== 2'b10 || unlocked !== 1'b0 || dut_out !== exp_out()) begin
         $display("FAIL relock_priority: mode=%b unlocked=%b want 10/0", disp_mode, unlocked);
         miscompares++;
      end
      vectors++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         int kind, p;
         logic [3:0] d;
         kind = $urandom_range(0, 9);
         p = m_prog ? m_plist.size() : m_att.size();
         if ($urandom_range(0, 3) != 0 && p < DIGITS) d = 4'(m_code[p]);
         else d = 4'($urandom_range(0, 15));
         if (kind <= 5)      apply(1'b1, d, 1'b0, 1'b0);
         else if (kind == 6) apply(1'b0, d, 1'b1, 1'b0);
         else if (kind == 7) apply(1'b0, d, 1'b0, 1'b1);
         else                apply(1'b0, d, 1'b0, 1'b0);
         if (dut_out !== exp_out()) begin
            $display("FAIL random[%0d]: dut=%h model=%h", n, dut_out, exp_out());
            miscompares++;
         end
         vectors++;
      end
   endtask

   initial begin
      test_reset();
      test_open();
      test_wrong_code();
      test_bad_digit();
      test_fail_limit();
      test_prog();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
